// File: rtl/uart_tx_engine.sv
// UART transmit engine: start bit, DATA_WIDTH data bits LSB first, optional
// even-parity bit, one stop bit. Every bit lasts (latched clk_div_i + 1) cycles.
// Optional feature macro: UART_TX_PARITY_EN (adds the even-parity bit).
// All outputs are registered; next values are computed from the next state.
module uart_tx_engine #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DIV_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  tx_start_i,
   input  logic [DATA_WIDTH-1:0] tx_data_i,
   input  logic [DIV_WIDTH-1:0]  clk_div_i,
   output logic                  tx_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  overrun_o
);

   localparam int unsigned      IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                r_state, w_state_nxt;
   logic [DIV_WIDTH-1:0]  r_cnt, w_cnt_nxt;
   logic [DIV_WIDTH-1:0]  r_div;
   logic [DATA_WIDTH-1:0] r_data;
   logic [IDX_W-1:0]      r_idx, w_idx_nxt;
   logic                  w_load;
   logic                  w_bit_end;
   logic                  w_tx_nxt;
   logic                  w_done_nxt;
   logic                  r_tx, r_busy, r_done, r_ovr;

   assign w_bit_end = (r_cnt == '0);

   // Next-state, bit-period counter and data-bit index sequencing.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_load      = 1'b0;
      case (r_state)
         IDLE: begin
            if (tx_start_i) begin
               w_load      = 1'b1;
               w_state_nxt = START;
               w_cnt_nxt   = clk_div_i;
            end
         end
         START: begin
            if (w_bit_end) begin
               w_state_nxt = DATA;
               w_cnt_nxt   = r_div;
               w_idx_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt - DIV_WIDTH'(1);
            end
         end
         DATA: begin
            if (w_bit_end) begin
               w_cnt_nxt = r_div;
               if (r_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                  w_state_nxt = PARITY;
`else
                  w_state_nxt = STOP;
`endif
               end else begin
                  w_idx_nxt = r_idx + IDX_W'(1);
               end
            end else begin
               w_cnt_nxt = r_cnt - DIV_WIDTH'(1);
            end
         end
         PARITY: begin
            if (w_bit_end) begin
               w_state_nxt = STOP;
               w_cnt_nxt   = r_div;
            end else begin
               w_cnt_nxt = r_cnt - DIV_WIDTH'(1);
            end
         end
         STOP: begin
            if (w_bit_end) begin
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt - DIV_WIDTH'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Line level and completion flag for the cycle the next state occupies.
   always_comb begin
      w_tx_nxt = 1'b1;
      case (w_state_nxt)
         START:   w_tx_nxt = 1'b0;
         DATA:    w_tx_nxt = r_data[w_idx_nxt];
         PARITY:  w_tx_nxt = ^r_data;
         default: w_tx_nxt = 1'b1;
      endcase
      w_done_nxt = (w_state_nxt == STOP) && (w_cnt_nxt == '0);
   end

   // State, counters and shadow copies of the accepted request.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_div   <= '0;
         r_data  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         if (w_load) begin
            r_data <= tx_data_i;
            r_div  <= clk_div_i;
         end
      end
   end

   // Registered outputs; a request seen while busy is flagged one cycle later.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_tx   <= 1'b1;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_ovr  <= 1'b0;
      end else begin
         r_tx   <= w_tx_nxt;
         r_busy <= (w_state_nxt != IDLE);
         r_done <= w_done_nxt;
         r_ovr  <= tx_start_i && r_busy;
      end
   end

   assign tx_o      = r_tx;
   assign busy_o    = r_busy;
   assign done_o    = r_done;
   assign overrun_o = r_ovr;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: directed scenarios plus randomized
// frames, each checked cycle by cycle against a frame built from bit lists.
module tb_uart_tx_engine;

   localparam int unsigned DW   = 8;
   localparam int unsigned DIVW = 16;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned NBITS = DW + 3;
`else
   localparam int unsigned NBITS = DW + 2;
`endif

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic            tx_start_i;
   logic [DW-1:0]   tx_data_i;
   logic [DIVW-1:0] clk_div_i;
   logic            tx_o;
   logic            busy_o;
   logic            done_o;
   logic            overrun_o;

   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk_i = ~clk_i;

   uart_tx_engine #(
      .DATA_WIDTH (DW),
      .DIV_WIDTH  (DIVW)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .tx_start_i (tx_start_i),
      .tx_data_i  (tx_data_i),
      .clk_div_i  (clk_div_i),
      .tx_o       (tx_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .overrun_o  (overrun_o)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input int unsigned k, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, k, obs, exp);
      end
   endtask

   task automatic chk_line(input string tag, input int unsigned k,
                           input logic e_tx, input logic e_busy,
                           input logic e_done, input logic e_ovr);
      chk({tag, ".tx"},      k, tx_o,      e_tx);
      chk({tag, ".busy"},    k, busy_o,    e_busy);
      chk({tag, ".done"},    k, done_o,    e_done);
      chk({tag, ".overrun"}, k, overrun_o, e_ovr);
   endtask

   task automatic idle(input int unsigned c);
      for (int unsigned i = 0; i < c; i++) begin
         chk_line("idle", i, 1'b1, 1'b0, 1'b0, 1'b0);
         tick();
      end
   endtask

   // Issues one request and checks every following cycle against the expected
   // line waveform. poke_at: frame cycle carrying an extra request (0 = none).
   // rst_at: frame cycle during which reset is asserted (0 = none).
   // jd/jdiv: values driven on the inputs after acceptance.
   // Returns positioned in the first cycle after the frame (already checked).
   task automatic frame(input logic [DW-1:0] d, input logic [DIVW-1:0] dv,
                        input int unsigned poke_at, input int unsigned rst_at,
                        input logic [DW-1:0] jd, input logic [DIVW-1:0] jdiv);
      logic        bits[$];
      logic        exp_q[$];
      int unsigned n;
      bits.push_back(1'b0);
      for (int unsigned i = 0; i < DW; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
      bits.push_back(^d);
`endif
      bits.push_back(1'b1);
      foreach (bits[b])
         for (int unsigned r = 0; r <= int'(dv); r++) exp_q.push_back(bits[b]);
      n = exp_q.size();

      tx_data_i  = d;
      clk_div_i  = dv;
      tx_start_i = 1'b1;
      tick();
      tx_start_i = 1'b0;
      tx_data_i  = jd;
      clk_div_i  = jdiv;

      for (int unsigned k = 1; k <= n + 1; k++) begin
         if (k <= n)
            chk_line("frame", k, exp_q[k-1], 1'b1, k == n, (poke_at != 0) && (k == poke_at + 1));
         else
            chk_line("after", k, 1'b1, 1'b0, 1'b0, poke_at == n);
         if (k == rst_at) begin
            rst_i = 1'b1;
            tick();
            rst_i = 1'b0;
            chk_line("abort", k + 1, 1'b1, 1'b0, 1'b0, 1'b0);
            return;
         end
         if (k <= n) begin
            if (k == poke_at) tx_start_i = 1'b1;
            tick();
            tx_start_i = 1'b0;
         end
      end
   endtask

   initial begin
      logic [DW-1:0]   rd, rjd;
      logic [DIVW-1:0] rdv, rjdiv;
      int unsigned     rpoke;

      // Reset, with a request present that must be ignored.
      rst_i      = 1'b1;
      tx_start_i = 1'b1;
      tx_data_i  = 8'hFF;
      clk_div_i  = '0;
      tick();
      tick();
      chk_line("reset", 0, 1'b1, 1'b0, 1'b0, 1'b0);
      rst_i      = 1'b0;
      tx_start_i = 1'b0;
      idle(2);

      // 0xA5 at 4 cycles per bit; inputs changed after acceptance.
      frame(8'hA5, 16'd3, 0, 0, 8'h00, 16'd9);
      idle(2);

`ifdef UART_TX_PARITY_EN
      frame(8'h07, 16'd0, 0, 0, 8'hFF, 16'd3);
      idle(1);
`endif

      // Extra request at frame cycle 10: overrun at 11, no second frame.
      frame(8'h5A, 16'd1, 10, 0, 8'h5A, 16'd1);
      idle(6);

      // Reset in the middle of the data bits, then a full frame.
      frame(8'hC3, 16'd2, 0, 14, 8'h00, 16'd0);
      idle(4);
      frame(8'hC3, 16'd2, 0, 0, 8'h00, 16'd0);
      idle(1);

      // Back-to-back: new request in the first idle cycle after done.
      frame(8'h81, 16'd1, 0, 0, 8'h00, 16'd0);
      frame(8'h3C, 16'd1, 0, 0, 8'h00, 16'd0);
      idle(2);

      // Divisor changed 5 -> 1 during a frame; next frame uses 2-cycle bits.
      frame(8'h96, 16'd5, 0, 0, 8'h96, 16'd1);
      frame(8'h69, 16'd1, 0, 0, 8'h00, 16'd7);
      idle(1);

      // Randomized frames, occasional extra requests and random gaps.
      for (int unsigned it = 0; it < 16; it++) begin
         rd    = DW'($urandom);
         rjd   = DW'($urandom);
         rdv   = DIVW'($urandom_range(0, 3));
         rjdiv = DIVW'($urandom_range(0, 7));
         rpoke = ($urandom_range(0, 2) == 0) ? $urandom_range(1, (int'(rdv) + 1) * NBITS) : 0;
         frame(rd, rdv, rpoke, 0, rjd, rjdiv);
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
